dsi_lane_distributor: RTL and testbench

DSI_LANE_DISTRIBUTOR -- requirements
Module: dsi_lane_distributor

---
 rtl/dsi_lane_distributor.sv | 181 ++++++++++++++++++
 tb/tb_dsi_lane_distributor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_lane_distributor.sv
// dsi_lane_distributor
// Spreads the byte stream of one HS burst across 1, 2 or 4 D-PHY data lanes.
// Accepted bytes go into a small circular byte buffer. Burst byte j is
// emitted on lane (j mod N), where N is the number of active lanes.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_data/in_strb     packet word, byte 0 in [7:0]; contiguous byte mask
//   in_valid/in_last    word valid / last word of the HS burst
//   in_ready            word accepted when in_valid && in_ready
//   lanes_num           0:1 lane, 1:2 lanes, 2:2 lanes, 3:4 lanes (read in IDLE)
//   lane_hs_rqst        per-lane HS request
//   lane_hs_ready       per-lane HS ready (one byte consumed per cycle)
//   lane_data/valid/last  registered per-lane byte, byte valid, final byte
//   underrun            sticky: buffer starved or lane dropped mid-burst
//   underrun_clr        clears underrun (a set in the same cycle wins)
//
// Optional feature: define DSI_LANE_DIST_STATS_EN to add output burst_bytes,
// the byte count of the last completed burst (saturating, 16 bits).
module dsi_lane_distributor #(
  parameter int BUF_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_strb,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [1:0]  lanes_num,
  output logic [3:0]  lane_hs_rqst,
  input  logic [3:0]  lane_hs_ready,
  output logic [31:0] lane_data,
  output logic [3:0]  lane_valid,
  output logic [3:0]  lane_last,
  output logic        underrun,
`ifdef DSI_LANE_DIST_STATS_EN
  output logic [15:0] burst_bytes,
`endif
  input  logic        underrun_clr
);

  localparam int PW = $clog2(BUF_BYTES);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RQST, S_STREAM, S_DRAIN} state_t;
  state_t state_reg, state_next;

  logic [7:0]    mem [BUF_BYTES];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg, remain, n_ext;
  logic [2:0]    n_reg, n_sel;
  logic          last_acc_reg, underrun_reg;
  logic [31:0]   lane_data_reg;
  logic [3:0]    lane_valid_reg, lane_last_reg;

  logic [3:0]    lane_mask, pop_valid, pop_last;
  logic          lanes_rdy, push_en, pop_en, final_pop, last_now, underrun_set;
  logic [2:0]    push_n, pop_n, pop_cnt;
  logic [31:0]   pop_data, pop_data_m;

  always_comb begin
    case (lanes_num)
      2'd0:    n_sel = 3'd1;
      2'd3:    n_sel = 3'd4;
      default: n_sel = 3'd2;
    endcase
    case (n_reg)
      3'd4:    lane_mask = 4'hF;
      3'd2:    lane_mask = 4'h3;
      default: lane_mask = 4'h1;
    endcase
  end

  assign n_ext     = CW'(n_reg);
  assign lanes_rdy = &(lane_hs_ready | ~lane_mask);
  assign in_ready  = ((state_reg == S_RQST) || (state_reg == S_STREAM)) &&
                     !last_acc_reg && (count_reg <= CW'(BUF_BYTES - 4));
  assign push_en   = in_valid && in_ready;
  assign push_n    = push_en ? (3'(in_strb[0]) + 3'(in_strb[1]) +
                                3'(in_strb[2]) + 3'(in_strb[3])) : 3'd0;

  // A short pop (fewer than N bytes) is only allowed once the burst end is known.
  assign pop_en    = (state_reg == S_STREAM) && lanes_rdy &&
                     ((count_reg >= n_ext) || (last_acc_reg && (count_reg != '0)));
  assign pop_n     = (count_reg >= n_ext) ? n_reg : count_reg[2:0];
  assign pop_cnt   = pop_en ? pop_n : 3'd0;
  assign remain    = count_reg - CW'(pop_cnt) + CW'(push_n);
  assign final_pop = pop_en && last_acc_reg && (count_reg == CW'(pop_n));

  // The last word may be accepted in the same cycle as a pop; counting it here
  // lets lanes that get nothing in the final pop flag their last byte in time.
  assign last_now  = last_acc_reg || (push_en && in_last);

  assign underrun_set = (state_reg == S_STREAM) &&
                        (!lanes_rdy || ((count_reg < n_ext) && !last_acc_reg));

  // Lane k takes the k-th byte of this pop. Its byte is that lane's final one
  // when the bytes still left after the pop cannot reach lane k again.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign pop_data[8*gi +: 8]   = mem[rd_ptr_reg + PW'(gi)];
    assign pop_valid[gi]         = pop_en && (3'(gi) < pop_n);
    assign pop_last[gi]          = pop_valid[gi] && last_now && (remain <= CW'(gi));
    assign pop_data_m[8*gi +: 8] = pop_valid[gi] ? pop_data[8*gi +: 8] : 8'h00;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (in_valid)  state_next = S_RQST;
      S_RQST:   if (lanes_rdy) state_next = S_STREAM;
      S_STREAM: if (final_pop) state_next = S_DRAIN;
      S_DRAIN:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Byte storage carries no reset; count_reg alone says what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < 4; i++) begin
        if (in_strb[i]) mem[wr_ptr_reg + PW'(i)] <= in_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      n_reg          <= 3'd1;
      count_reg      <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      last_acc_reg   <= 1'b0;
      underrun_reg   <= 1'b0;
      lane_data_reg  <= '0;
      lane_valid_reg <= '0;
      lane_last_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == S_IDLE) && in_valid) n_reg <= n_sel;
      if (state_reg == S_IDLE)           last_acc_reg <= 1'b0;
      else if (push_en && in_last)       last_acc_reg <= 1'b1;
      count_reg      <= remain;
      rd_ptr_reg     <= rd_ptr_reg + PW'(pop_cnt);
      wr_ptr_reg     <= wr_ptr_reg + PW'(push_n);
      lane_data_reg  <= pop_data_m;
      lane_valid_reg <= pop_valid;
      lane_last_reg  <= pop_last;
      if (underrun_set)      underrun_reg <= 1'b1;
      else if (underrun_clr) underrun_reg <= 1'b0;
    end
  end

`ifdef DSI_LANE_DIST_STATS_EN
  logic [15:0] burst_cnt_reg, burst_bytes_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_reg   <= '0;
      burst_bytes_reg <= '0;
    end else begin
      if (state_reg == S_IDLE)
        burst_cnt_reg <= '0;
      else if (push_en)
        burst_cnt_reg <= (burst_cnt_reg > (16'hFFFF - 16'(push_n))) ? 16'hFFFF
                                                                   : burst_cnt_reg + 16'(push_n);
      if (final_pop) burst_bytes_reg <= burst_cnt_reg;
    end
  end

  assign burst_bytes = burst_bytes_reg;
`endif

  assign lane_hs_rqst = ((state_reg == S_RQST) || (state_reg == S_STREAM)) ? lane_mask : 4'h0;
  assign lane_data    = lane_data_reg;
  assign lane_valid   = lane_valid_reg;
  assign lane_last    = lane_last_reg;
  assign underrun     = underrun_reg;

endmodule

// File: tb/tb_dsi_lane_distributor.sv
// Testbench for dsi_lane_distributor: directed bursts, per-lane expected
// byte queues built from the lane-assignment rule, literal spot checks.
module tb_dsi_lane_distributor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_strb;
  logic        in_valid, in_last, in_ready;
  logic [1:0]  lanes_num;
  logic [3:0]  lane_hs_rqst, lane_hs_ready;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid, lane_last;
  logic        underrun, underrun_clr;
`ifdef DSI_LANE_DIST_STATS_EN
  logic [15:0] burst_bytes;
`endif

  always #5 clk = ~clk;

  dsi_lane_distributor #(.BUF_BYTES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_strb      (in_strb),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .lanes_num    (lanes_num),
    .lane_hs_rqst (lane_hs_rqst),
    .lane_hs_ready(lane_hs_ready),
    .lane_data    (lane_data),
    .lane_valid   (lane_valid),
    .lane_last    (lane_last),
    .underrun     (underrun),
`ifdef DSI_LANE_DIST_STATS_EN
    .burst_bytes  (burst_bytes),
`endif
    .underrun_clr (underrun_clr)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: expected {last, byte} per lane, in emission order.
  logic [8:0]  exp_q [4][$];
  int          model_n = 1;
  bit          quiet   = 1'b0;
  int          valid_cycles;
  logic [3:0]  last_valid_seen, last_last_seen;
  logic [31:0] first_data_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Burst byte j goes to lane j mod n; it is that lane's last byte when no
  // later byte of the burst lands on the same lane.
  task automatic expect_burst(input int n, input int nbytes, input int start);
    model_n = n;
    for (int j = 0; j < nbytes; j++)
      exp_q[j % n].push_back({(j + n >= nbytes), 8'(start + j)});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (lane_valid != 4'h0) begin
        if (valid_cycles == 0) first_data_seen = lane_data;
        valid_cycles++;
        last_valid_seen = lane_valid;
        last_last_seen  = lane_last;
        if (quiet) check("quiet_lane_valid", 32'(lane_valid), 32'h0);
        check("lane_valid_prefix", 32'(lane_valid & (lane_valid + 4'd1)), 32'h0);
      end
      for (int k = 0; k < 4; k++) begin
        if (lane_valid[k]) begin
          if (k >= model_n)
            check($sformatf("lane%0d_inactive", k), 32'(lane_valid[k]), 32'h0);
          else if (exp_q[k].size() == 0)
            check($sformatf("lane%0d_extra_byte", k), 32'(lane_data[8*k +: 8]), 32'hDEAD);
          else begin
            logic [8:0] e;
            e = exp_q[k].pop_front();
            check($sformatf("lane%0d_last_byte", k), {23'b0, lane_last[k], lane_data[8*k +: 8]}, {23'b0, e});
          end
        end else if (lane_last[k]) begin
          check($sformatf("lane%0d_last_no_valid", k), 32'(lane_last[k]), 32'h0);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [3:0] s, input logic l);
    int t;
    t = 0;
    in_data = d; in_strb = s; in_last = l; in_valid = 1'b1;
    #1;
    while (!in_ready && t < 200) begin
      @(negedge clk); #1; t++;
    end
    check("in_ready_timeout", 32'(in_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_bytes(input int nbytes, input int start);
    int j, k;
    logic [31:0] d;
    logic [3:0]  s;
    j = 0;
    while (j < nbytes) begin
      k = (nbytes - j >= 4) ? 4 : nbytes - j;
      d = 32'hEEEEEEEE; s = 4'h0;
      for (int i = 0; i < k; i++) begin
        d[8*i +: 8] = 8'(start + j + i);
        s[i] = 1'b1;
      end
      send_word(d, s, (j + k >= nbytes));
      j += k;
    end
  endtask

  task automatic wait_done(input string name);
    int t;
    bit done;
    t = 0; done = 1'b0;
    while (!done && t < 3000) begin
      @(negedge clk); #1; t++;
      done = (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) &&
             (lane_hs_rqst == 4'h0);
    end
    check({name, "_done"}, 32'(done), 32'h1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_strb = 4'h0; in_data = 32'h0;
    underrun_clr = 1'b0; lane_hs_ready = 4'hF; quiet = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    valid_cycles = 0; last_valid_seen = 4'h0; last_last_seen = 4'h0; first_data_seen = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lanes_num = 2'd0;
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_hs_rqst", 32'(lane_hs_rqst), 32'h0);
    check("rst_lane_valid", 32'(lane_valid), 32'h0);
    check("rst_lane_last", 32'(lane_last), 32'h0);
    check("rst_lane_data", lane_data, 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
`ifdef DSI_LANE_DIST_STATS_EN
    check("rst_burst_bytes", 32'(burst_bytes), 32'h0);
`endif

    // 4 lanes, 12 bytes: three full cycles, all lanes last on the third.
    lanes_num = 2'd3;
    expect_burst(4, 12, 0);
    send_bytes(12, 0);
    wait_done("t1");
    check("t1_valid_cycles", 32'(valid_cycles), 32'd3);
    check("t1_final_last", 32'(last_last_seen), 32'hF);
    check("t1_first_data", first_data_seen, 32'h03020100);

    // 2 lanes, 7 bytes: lane1 ends on 05, lane0 on 06 alone.
    do_reset();
    lanes_num = 2'd1;
    expect_burst(2, 7, 0);
    send_bytes(7, 0);
    wait_done("t2");
    check("t2_valid_cycles", 32'(valid_cycles), 32'd4);
    check("t2_final_valid", 32'(last_valid_seen), 32'h1);
    check("t2_final_last", 32'(last_last_seen), 32'h1);
    check("t2_first_data", 32'(first_data_seen[15:0]), 32'h0100);

    // 1 lane that never becomes ready: request held, buffer fills, nothing out.
    do_reset();
    lanes_num = 2'd0;
    lane_hs_ready = 4'h0;
    expect_burst(1, 9, 8'h10);
    send_word(32'h13121110, 4'hF, 1'b0);
    #1;
    check("t3_ready_half", 32'(in_ready), 32'h1);
    send_word(32'h17161514, 4'hF, 1'b0);
    #1;
    check("t3_ready_full", 32'(in_ready), 32'h0);
    check("t3_rqst", 32'(lane_hs_rqst), 32'h1);
    quiet = 1'b1;
    repeat (18) @(negedge clk);
    #1;
    quiet = 1'b0;
    check("t3_ready_held", 32'(in_ready), 32'h0);
    check("t3_rqst_held", 32'(lane_hs_rqst), 32'h1);
    check("t3_no_output", 32'(valid_cycles), 32'd0);
    lane_hs_ready = 4'hF;
    send_word(32'hEEEEEE18, 4'b0001, 1'b1);
    wait_done("t3");

    // 4 lanes starved after one word: underrun sets, gap is silent, then clears.
    do_reset();
    lanes_num = 2'd3;
    expect_burst(4, 8, 8'h20);
    send_word(32'h23222120, 4'hF, 1'b0);
    @(negedge clk);
    #1;
    quiet = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    quiet = 1'b0;
    check("t4_underrun_set", 32'(underrun), 32'h1);
    check("t4_gap_one_pop", 32'(valid_cycles), 32'd1);
    send_word(32'h27262524, 4'hF, 1'b1);
    wait_done("t4");
    check("t4_underrun_sticky", 32'(underrun), 32'h1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    #1;
    check("t4_underrun_clr", 32'(underrun), 32'h0);

    // 2 lanes, lane1 drops out mid-stream, lanes_num change ignored.
    do_reset();
    lanes_num = 2'd2;
    expect_burst(2, 10, 8'h40);
    fork
      send_bytes(10, 8'h40);
      begin
        repeat (2) @(negedge clk);
        #2 lanes_num = 2'd3;
        @(negedge clk);
        #2 check("t5_rqst_latched", 32'(lane_hs_rqst), 32'h3);
        lane_hs_ready = 4'b1101;
        repeat (2) @(negedge clk);
        #2 lane_hs_ready = 4'hF;
      end
    join
    wait_done("t5");
    check("t5_underrun", 32'(underrun), 32'h1);

    // Reset mid-burst with 6 bytes buffered, then a clean 4-lane burst.
    do_reset();
    lanes_num = 2'd3;
    lane_hs_ready = 4'h0;
    send_word(32'h53525150, 4'hF, 1'b0);
    send_word(32'hEEEE5554, 4'b0011, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rqst_async", 32'(lane_hs_rqst), 32'h0);
    @(negedge clk);
    check("t6_in_ready", 32'(in_ready), 32'h0);
    check("t6_rqst", 32'(lane_hs_rqst), 32'h0);
    check("t6_lane_valid", 32'(lane_valid), 32'h0);
    check("t6_lane_last", 32'(lane_last), 32'h0);
    check("t6_lane_data", lane_data, 32'h0);
    check("t6_underrun", 32'(underrun), 32'h0);
    do_reset();
    lanes_num = 2'd3;
    expect_burst(4, 4, 0);
    send_bytes(4, 0);
    wait_done("t6");
    check("t6_first_data", first_data_seen, 32'h03020100);
    check("t6_final_last", 32'(last_last_seen), 32'hF);

`ifdef DSI_LANE_DIST_STATS_EN
    do_reset();
    lanes_num = 2'd3;
    expect_burst(4, 4094, 0);
    send_bytes(4094, 0);
    wait_done("t7");
    check("t7_burst_bytes", 32'(burst_bytes), 32'd4094);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
